// File: rtl/irq_request_latch.sv
// Interrupt request front-end: synchronises eight request lines, latches rising edges
// as sticky pending bits with overflow tracking, and drives irq with a post-clear hold-off.
module irq_request_latch #(
    parameter int unsigned HOLDOFF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       clr_valid,
    input  logic [2:0] clr_idx,
    output logic [7:0] pend,
    output logic       irq,
    output logic [7:0] ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_INIT = (HOLDOFF == 0) ? 4'd0 : 4'(HOLDOFF - 1);

    logic [7:0] s1_q, s2_q, s3_q;
    logic [7:0] rawPend_q, rawPend_d;
    logic [7:0] ovf_q, ovf_d;
    logic [7:0] rise, clrHit;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // A new edge always wins over a clear of the same line; overflow is then left untouched.
    always_comb begin
        rise      = s2_q & ~s3_q;
        clrHit    = clr_valid ? (8'd1 << clr_idx) : 8'd0;
        rawPend_d = rise | (rawPend_q & ~clrHit);
        ovf_d     = (rise & rawPend_q & ~clrHit) | (ovf_q & ~(clrHit & ~rise));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|pend) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (clr_valid) begin
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = CNT_INIT;
                    end
                end else if (pend == 8'd0) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= 8'd0;
            s2_q      <= 8'd0;
            s3_q      <= 8'd0;
            rawPend_q <= 8'd0;
            ovf_q     <= 8'd0;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
        end else begin
            s1_q      <= req;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            rawPend_q <= rawPend_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pend = rawPend_q & mask;
    assign irq  = (state_q == ACTIVE);
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench: expected pend/irq/ovf are queued with each stimulus cycle and checked
// after the edge; a second instance with HOLDOFF=4 shares the stimulus.
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       clr_valid;
    logic [2:0] clr_idx;
    logic [7:0] pend, pend4;
    logic       irq, irq4;
    logic [7:0] ovf, ovf4;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string      tag;
        logic [7:0] pend;
        logic       irq;
        logic [7:0] ovf;
        bit         chk4;
        logic       irq4;
    } exp_t;

    exp_t sb[$];

    irq_request_latch #(.HOLDOFF(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .clr_valid(clr_valid),
        .clr_idx(clr_idx), .pend(pend), .irq(irq), .ovf(ovf)
    );

    irq_request_latch #(.HOLDOFF(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .clr_valid(clr_valid),
        .clr_idx(clr_idx), .pend(pend4), .irq(irq4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic [7:0] rq,
                                 input logic [7:0] m, input logic cv, input logic [2:0] ci,
                                 input logic [7:0] ePend, input logic eIrq, input logic [7:0] eOvf,
                                 input bit chk4, input logic eIrq4);
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        req       = rq;
        mask      = m;
        clr_valid = cv;
        clr_idx   = ci;
        e.tag  = tag;
        e.pend = ePend;
        e.irq  = eIrq;
        e.ovf  = eOvf;
        e.chk4 = chk4;
        e.irq4 = eIrq4;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("scoreboardEmpty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            checkOutput({e.tag, ".pend"}, pend, e.pend);
            checkOutput({e.tag, ".irq"}, {7'd0, irq}, {7'd0, e.irq});
            checkOutput({e.tag, ".ovf"}, ovf, e.ovf);
            if (e.chk4) checkOutput({e.tag, ".irq4"}, {7'd0, irq4}, {7'd0, e.irq4});
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [7:0] rq, input logic [7:0] m,
                        input logic cv, input logic [2:0] ci, input logic [7:0] ePend,
                        input logic eIrq, input logic [7:0] eOvf);
        applyStimulus(tag, r, rq, m, cv, ci, ePend, eIrq, eOvf, 1'b0, 1'b0);
        collect();
    endtask

    task automatic step4(input string tag, input logic r, input logic [7:0] rq, input logic cv,
                         input logic [2:0] ci, input logic [7:0] ePend, input logic eIrq,
                         input logic eIrq4);
        applyStimulus(tag, r, rq, 8'hFF, cv, ci, ePend, eIrq, 8'h00, 1'b1, eIrq4);
        collect();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0; req = 8'hFF; mask = 8'hFF; clr_valid = 1'b0; clr_idx = 3'd0;

        step("rst1", 0, 8'hFF, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("rst2", 0, 8'hFF, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("rst3", 0, 8'h00, 8'hFF, 0, 0, 8'h00, 0, 8'h00);

        step("single0", 1, 8'h00, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("single1", 1, 8'h20, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("single2", 1, 8'h20, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("single3", 1, 8'h20, 8'hFF, 0, 0, 8'h20, 0, 8'h00);
        step("single4", 1, 8'h20, 8'hFF, 0, 0, 8'h20, 1, 8'h00);
        step("clr5",    1, 8'h20, 8'hFF, 1, 5, 8'h00, 0, 8'h00);
        step("hold1",   1, 8'h20, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("hold2",   1, 8'h20, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("idle",    1, 8'h20, 8'hFF, 0, 0, 8'h00, 0, 8'h00);

        step("b2b1", 1, 8'h64, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("b2b2", 1, 8'h64, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("b2b3", 1, 8'h64, 8'hFF, 0, 0, 8'h44, 0, 8'h00);
        step("b2b4", 1, 8'h64, 8'hFF, 0, 0, 8'h44, 1, 8'h00);
        step("clr6", 1, 8'h64, 8'hFF, 1, 6, 8'h04, 0, 8'h00);
        step("b2bH1", 1, 8'h64, 8'hFF, 0, 0, 8'h04, 0, 8'h00);
        step("b2bH2", 1, 8'h64, 8'hFF, 0, 0, 8'h04, 0, 8'h00);
        step("b2bRe", 1, 8'h64, 8'hFF, 0, 0, 8'h04, 1, 8'h00);
        step("clr2",  1, 8'h64, 8'hFF, 1, 2, 8'h00, 0, 8'h00);
        step("clr2H", 1, 8'h64, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("clr2I", 1, 8'h64, 8'hFF, 0, 0, 8'h00, 0, 8'h00);

        step("ovfA1", 1, 8'h6C, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("ovfA2", 1, 8'h64, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("ovfA3", 1, 8'h64, 8'hFF, 0, 0, 8'h08, 0, 8'h00);
        step("ovfB1", 1, 8'h6C, 8'hFF, 0, 0, 8'h08, 1, 8'h00);
        step("ovfB2", 1, 8'h64, 8'hFF, 0, 0, 8'h08, 1, 8'h00);
        step("ovfSet", 1, 8'h64, 8'hFF, 0, 0, 8'h08, 1, 8'h08);
        step("collC1", 1, 8'h6C, 8'hFF, 0, 0, 8'h08, 1, 8'h08);
        step("collC2", 1, 8'h64, 8'hFF, 0, 0, 8'h08, 1, 8'h08);
        step("collide", 1, 8'h64, 8'hFF, 1, 3, 8'h08, 0, 8'h08);
        step("collH1", 1, 8'h64, 8'hFF, 0, 0, 8'h08, 0, 8'h08);
        step("collH2", 1, 8'h64, 8'hFF, 0, 0, 8'h08, 0, 8'h08);
        step("collRe", 1, 8'h64, 8'hFF, 0, 0, 8'h08, 1, 8'h08);
        step("clr3",   1, 8'h64, 8'hFF, 1, 3, 8'h00, 0, 8'h00);
        step("clr3H",  1, 8'h64, 8'hFF, 0, 0, 8'h00, 0, 8'h00);
        step("clr3I",  1, 8'h64, 8'hFF, 0, 0, 8'h00, 0, 8'h00);

        step("mask1", 1, 8'h66, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        step("mask2", 1, 8'h66, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        step("mask3", 1, 8'h66, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        step("mask4", 1, 8'h66, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        applyStimulus("unmask", 1, 8'h66, 8'h02, 0, 0, 8'h02, 1, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("unmaskSameCycle.pend", pend, 8'h02);
        checkOutput("unmaskSameCycle.irq", {7'd0, irq}, 8'h00);
        collect();
        step("withdraw", 1, 8'h66, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        step("clrMasked", 1, 8'h66, 8'h00, 1, 1, 8'h00, 0, 8'h00);
        step("reveal",   1, 8'h66, 8'hFF, 0, 0, 8'h00, 0, 8'h00);

        step4("h4rst",  0, 8'h00, 0, 0, 8'h00, 0, 0);
        step4("h4a",    1, 8'h30, 0, 0, 8'h00, 0, 0);
        step4("h4b",    1, 8'h30, 0, 0, 8'h00, 0, 0);
        step4("h4c",    1, 8'h30, 0, 0, 8'h30, 0, 0);
        step4("h4act",  1, 8'h30, 0, 0, 8'h30, 1, 1);
        step4("h4clr4", 1, 8'h30, 1, 4, 8'h20, 0, 0);
        step4("h4w1",   1, 8'h30, 0, 0, 8'h20, 0, 0);
        step4("h4w2",   1, 8'h30, 0, 0, 8'h20, 0, 0);
        step4("h4w3",   1, 8'h30, 0, 0, 8'h20, 1, 0);
        step4("h4w4",   1, 8'h30, 0, 0, 8'h20, 1, 0);
        step4("h4re",   1, 8'h30, 0, 0, 8'h20, 1, 1);
        step4("h4clr5", 1, 8'h30, 1, 5, 8'h00, 0, 0);
        step4("h4hold", 1, 8'h30, 0, 0, 8'h00, 0, 0);
        step4("h4midRst", 0, 8'h00, 0, 0, 8'h00, 0, 0);
        step4("post1",  1, 8'h01, 0, 0, 8'h00, 0, 0);
        step4("post2",  1, 8'h01, 0, 0, 8'h00, 0, 0);
        step4("post3",  1, 8'h01, 0, 0, 8'h01, 0, 0);
        step4("post4",  1, 8'h01, 0, 0, 8'h01, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
